karatsuba_seq_mult: RTL

KARATSUBA_SEQ_MULT -- requirements
Module: karatsuba_seq_mult

---
 rtl/karatsuba_seq_mult_if.sv | 31 +++
 rtl/karatsuba_seq_mult.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_mult_if.sv
// Handshake and data bundle for karatsuba_seq_mult.
//   in_valid/in_ready  : operand offer / block can accept
//   a, b, mode         : operands; mode 0 = integer, 1 = carry-less GF(2)[x]
//   out_valid/out_ready: product available / consumer accepts
//   p                  : 2W-bit product
//   busy               : block is not idle
// The master side is the producer/consumer around the multiplier.
// The slave side is the multiplier itself.
interface karatsuba_seq_mult_if #(
    parameter int W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   p;
    logic             busy;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/karatsuba_seq_mult.sv
// Sequential Karatsuba multiplier, W x W -> 2W bits.
// One shared (H+1)x(H+1) multiplier, H = W/2, is used once per cycle to
// form three partial products. Mode 0 is an integer multiply. Mode 1 is a
// carry-less GF(2)[x] multiply, where every add or subtract becomes XOR.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : karatsuba_seq_mult_if slave modport (handshake, operands, product)
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for an operand set; in_ready high
// S_MUL_HI  | k1 = ah*bh
// S_MUL_LO  | k2 = al*bl
// S_MUL_MID | k3 = (ah+al)*(bh+bl), or the XOR sums in mode 1
// S_COMBINE | assemble p, raise out_valid
// S_DONE    | hold p/out_valid until out_ready
module karatsuba_seq_mult #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    karatsuba_seq_mult_if.slave  bus
);
    localparam int H  = W / 2;
    localparam int KW = 2 * H + 2;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL_HI, S_MUL_LO, S_MUL_MID, S_COMBINE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            mode_q, mode_d;
    logic [KW-1:0]   k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [PW-1:0]   p_q, p_d;
    logic            out_valid_q, out_valid_d;

    logic [H:0]      mul_x, mul_y;
    logic [KW-1:0]   mul_out;
    logic [PW-1:0]   k1_e, k2_e, k3_e;
    logic [PW-1:0]   mid_int, p_int, p_clm;

    function automatic logic [KW-1:0] clmul(input logic [H:0] x, input logic [H:0] y);
        logic [KW-1:0] r;
        r = '0;
        for (int i = 0; i <= H; i++) begin
            if (y[i]) r = r ^ (KW'(x) << i);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] rca(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                          input logic cin);
        logic [PW-1:0] s;
        logic          c;
        c = cin;
        for (int i = 0; i < PW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return s;
    endfunction

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            S_MUL_HI: begin
                mul_x = {1'b0, a_q[W-1:H]};
                mul_y = {1'b0, b_q[W-1:H]};
            end
            S_MUL_LO: begin
                mul_x = {1'b0, a_q[H-1:0]};
                mul_y = {1'b0, b_q[H-1:0]};
            end
            default: begin
                if (mode_q) begin
                    mul_x = {1'b0, a_q[W-1:H] ^ a_q[H-1:0]};
                    mul_y = {1'b0, b_q[W-1:H] ^ b_q[H-1:0]};
                end else begin
                    // H+1 bit sums keep the carry out of the half-word add.
                    mul_x = {1'b0, a_q[W-1:H]} + {1'b0, a_q[H-1:0]};
                    mul_y = {1'b0, b_q[W-1:H]} + {1'b0, b_q[H-1:0]};
                end
            end
        endcase
        mul_out = mode_q ? clmul(mul_x, mul_y) : (KW'(mul_x) * KW'(mul_y));
    end

    // Recombination. The middle term k3-k1-k2 equals ah*bl+al*bh, so it is
    // never negative and the 2W-bit two's-complement subtraction is exact.
    always_comb begin
        k1_e    = PW'(k1_q);
        k2_e    = PW'(k2_q);
        k3_e    = PW'(k3_q);
        mid_int = rca(rca(k3_e, ~k1_e, 1'b1), ~k2_e, 1'b1);
        p_int   = rca(rca(k1_e << W, mid_int << H, 1'b0), k2_e, 1'b0);
        p_clm   = (k1_e << W) ^ ((k3_e ^ k1_e ^ k2_e) << H) ^ k2_e;
        // Carry-less product of two W-bit polynomials has degree <= 2W-2.
        p_clm[PW-1] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        k3_d        = k3_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    mode_d  = bus.mode;
                    state_d = S_MUL_HI;
                end
            end
            S_MUL_HI: begin
                k1_d    = mul_out;
                state_d = S_MUL_LO;
            end
            S_MUL_LO: begin
                k2_d    = mul_out;
                state_d = S_MUL_MID;
            end
            S_MUL_MID: begin
                k3_d    = mul_out;
                state_d = S_COMBINE;
            end
            S_COMBINE: begin
                p_d         = mode_q ? p_clm : p_int;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            k3_q        <= k3_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
endmodule
